seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised multi-cycle non-restoring integer divider. Successor to the fixed 64-bit divider.
- Adds a start/done handshake, a runtime signed/unsigned mode, divide-by-zero and signed-overflow handling, and a correctly sized remainder.
- Serves as the shared divide unit behind the ALU.
- Computes one quotient bit per clock.

Parameters:
- WIDTH, 64, operand, quotient and remainder width in bits; legal range 4..64.
- SIGNED_EN, 1, when 0 the signed datapath is not built and signed_mode is ignored (treated as 0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement divide; 0 = unsigned. Sampled with start.
- dividend  input  WIDTH  captured on start acceptance.
- divisor  input  WIDTH  captured on start acceptance.
- busy  output  1  high while a request is in flight (CALC/FIX).
- done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid in that cycle.
- quotient  output  WIDTH  registered; holds value until next done.
- remainder  output  WIDTH  registered; holds value until next done.
- div_by_zero  output  1  registered flag for the last result.

Behaviour:
- Reset (sync, rst=1 at rising edge):
  - state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0.
  - rst during CALC/FIX aborts the operation; no done is produced.
  - rst has priority over start.
- States: IDLE -> CALC -> FIX -> IDLE. A divisor of zero bypasses CALC: IDLE -> FIX -> IDLE.
- IDLE:
  - On start=1, capture sign flags (dividend[W-1], divisor[W-1], gated by signed_mode and SIGNED_EN).
  - Capture magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values; |min_neg| = 2^(W-1) fits.
  - Clear partial remainder P (WIDTH+1 bits, signed) and the counter.
  - Go to CALC, or to FIX if divisor==0.
- CALC, one iteration per cycle, WIDTH cycles:
  - {P,Q} shifted left 1.
  - If P>=0 then P-=M, else P+=M.
  - Q[0] = ~P_new[W].
  - The counter advances each iteration and its reached flag moves the state to FIX after the WIDTH-th iteration.
- FIX, one cycle:
  - Correction: if P<0 then P+=M.
  - Apply signs: quotient negated if the dividend and divisor signs differ (truncation toward zero). Remainder negated if the dividend is negative.
  - Register outputs and assert done at the same edge. Return to IDLE.
- Latency:
  - start accepted at edge N; done high in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles.
  - Divide-by-zero: done high after edge N+1, i.e. 2 cycles.
- busy: high from the cycle after acceptance through FIX; low in the done cycle.
- Handshake:
  - start while busy is ignored; no queueing.
  - start in the done cycle is accepted (state is IDLE); back-to-back throughput is one result per WIDTH+2 cycles.
  - Operands need not be held after acceptance.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified), div_by_zero=1.
- Signed overflow (min_neg / -1, signed_mode=1): quotient = min_neg, remainder = 0, div_by_zero=0. This falls out of the magnitude datapath; no special case is needed beyond truncation to WIDTH.
- Invariant for all non-zero divisors: dividend == quotient*divisor + remainder (mod 2^W), and |remainder| < |divisor|.

Decomposition:
- Package div_pkg:
  - state enum div_state_t {IDLE, CALC, FIX}.
  - function div_latency(width) = width+2.
  - Constants for the divide-by-zero quotient pattern.
- Sub-module: iteration_counter, a parametrised successor of the fixed 64-count counter.
  - Parameters: COUNT.
  - Ports: clk, rst, clear, enable, count, reached.
  - Width $clog2(COUNT+1).
  - reached is high when count==COUNT-1 and enable=1.

Test Plan:
- WIDTH=64, unsigned, 11/3 -> quotient=3, remainder=2, done exactly 66 cycles after start, busy low in done cycle.
- WIDTH=8, signed, -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1); 7/-2 -> quotient=0xFD, remainder=0x01.
- WIDTH=8, signed, 0x80/0xFF -> quotient=0x80, remainder=0x00, div_by_zero=0; same operands unsigned -> quotient=0x00, remainder=0x80.
- WIDTH=64, 1234/0 -> done 2 cycles after start, quotient=all ones, remainder=1234, div_by_zero=1; the next valid divide clears div_by_zero.
- Handshake: start held high continuously with changing operands -> only the operands present on acceptance cycles are used; a second start issued during busy is dropped; start in the done cycle yields the next done after a further WIDTH+2 cycles.
- Reset mid-CALC, asserted at iteration 20 -> no done pulse; outputs are 0 the cycle after reset; a fresh 100/7 then gives quotient=14, remainder=2.

Source files
------------

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : div_pkg                                               |
// | Purpose  : Shared types and constants for the sequential divider |
// | Revision : 1.0 - initial parametrised release                    |
// +------------------------------------------------------------------+
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Widest supported operand; narrower instances slice the constant below.
    localparam int c_max_width = 64;

    // Quotient reported when the divisor is zero.
    localparam logic [c_max_width-1:0] c_dbz_quotient = {c_max_width{1'b1}};

    // Cycles from the cycle start is presented to the cycle done is high.
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : iteration_counter                                     |
// | Purpose  : Counts divider iterations, flags the final one        |
// | Revision : 1.0 - parametrised successor of fixed 64-count counter|
// +------------------------------------------------------------------+
module iteration_counter #(
    parameter int COUNT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enable,
    output logic [$clog2(COUNT+1)-1:0] count,
    output logic                       reached
);

    localparam int c_cw = $clog2(COUNT + 1);

    // Iteration count: cleared on a new request, advances once per iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + c_cw'(1);
        end
    end

    // High during the last iteration so the FSM leaves CALC right after it.
    assign reached = enable && (count == c_cw'(COUNT - 1));

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : seq_divider                                           |
// | Purpose  : Multi-cycle non-restoring divider, one bit per clock, |
// |            signed/unsigned, divide-by-zero reporting             |
// | Revision : 1.0 - parametrised successor of fixed 64-bit divider  |
// +------------------------------------------------------------------+
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_cw = $clog2(WIDTH + 1);

    div_state_t       r_state, w_state_next;
    logic             w_sign_mode;
    logic             w_dvd_neg, w_dvs_neg, w_divisor_zero;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic             r_neg_q, r_neg_r, r_dbz;
    logic [WIDTH-1:0] r_m, r_q;
    logic [WIDTH:0]   r_p;
    logic             w_load, w_iterate, w_finish;
    logic [c_cw-1:0]  w_iter_count;
    logic             w_reached;
    logic [WIDTH:0]   w_m_ext, w_p_shift, w_p_next, w_p_fix;
    logic [WIDTH-1:0] w_q_next, w_rem_mag, w_quot_res, w_rem_res;

    // Signed mode only exists when the signed datapath is built.
    if (SIGNED_EN) begin : g_signed
        assign w_sign_mode = signed_mode;
    end else begin : g_unsigned
        assign w_sign_mode = 1'b0;
    end

    // Operand magnitudes; |min_neg| = 2^(W-1) is representable unsigned.
    assign w_dvd_neg      = w_sign_mode & dividend[WIDTH-1];
    assign w_dvs_neg      = w_sign_mode & divisor[WIDTH-1];
    assign w_dvd_mag      = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag      = w_dvs_neg ? -divisor  : divisor;
    assign w_divisor_zero = (divisor == '0);

    // One non-restoring step. P may wrap mod 2^(W+1) during the shift, but
    // the add/sub result always lies in [-M, M) so it comes out exact.
    assign w_m_ext   = {1'b0, r_m};
    assign w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_p_next  = r_p[WIDTH] ? (w_p_shift + w_m_ext) : (w_p_shift - w_m_ext);
    assign w_q_next  = {r_q[WIDTH-2:0], ~w_p_next[WIDTH]};

    // Final remainder correction and sign application.
    assign w_p_fix    = r_p[WIDTH] ? (r_p + w_m_ext) : r_p;
    assign w_rem_mag  = w_p_fix[WIDTH-1:0];
    assign w_quot_res = r_neg_q ? -r_q : r_q;
    assign w_rem_res  = r_neg_r ? -w_rem_mag : w_rem_mag;

    iteration_counter #(
        .COUNT (WIDTH)
    ) u_iter_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_load),
        .enable  (w_iterate),
        .count   (w_iter_count),
        .reached (w_reached)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_iterate    = 1'b0;
        w_finish     = 1'b0;
        busy         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = w_divisor_zero ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                // Guard keeps a corrupted count from iterating past WIDTH.
                w_iterate = (w_iter_count != c_cw'(WIDTH));
                if (w_reached) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                busy         = 1'b1;
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_m         <= '0;
            r_q         <= '0;
            r_p         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= w_finish;
            if (w_load) begin
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
                r_dbz   <= w_divisor_zero;
                r_m     <= w_dvs_mag;
                // Divide-by-zero returns the raw dividend, so keep it unmodified.
                r_q     <= w_divisor_zero ? dividend : w_dvd_mag;
                r_p     <= '0;
            end else if (w_iterate) begin
                r_p <= w_p_next;
                r_q <= w_q_next;
            end
            if (w_finish) begin
                if (r_dbz) begin
                    quotient    <= c_dbz_quotient[WIDTH-1:0];
                    remainder   <= r_q;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= w_quot_res;
                    remainder   <= w_rem_res;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_seq_divider                                        |
// | Purpose  : Self-checking bench for seq_divider (8- and 64-bit)   |
// | Revision : 1.0 - initial                                         |
// +------------------------------------------------------------------+
module tb_seq_divider;
    import div_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start64, sm64, busy64, done64, z64;
    logic [63:0] a64, b64, q64, r64;
    logic        start8, sm8, busy8, done8, z8;
    logic [7:0]  a8, b8, q8, r8;

    seq_divider #(.WIDTH(64), .SIGNED_EN(1)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .signed_mode(sm64),
        .dividend(a64), .divisor(b64), .busy(busy64), .done(done64),
        .quotient(q64), .remainder(r64), .div_by_zero(z64)
    );

    seq_divider #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       sm;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec8_t;

    vec8_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one request, release start after acceptance, scramble the
    // operands, and wait (bounded) for done.
    task automatic run_div(input bit w8, input logic sm, input logic [63:0] a, input logic [63:0] b,
                           output int lat, output logic [63:0] q, output logic [63:0] r,
                           output logic z, output logic busy_d, output logic busy_1);
        if (w8) begin start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin start64 = 1'b1; sm64 = sm; a64 = a; b64 = b; end
        @(posedge clk); #1;
        start8 = 1'b0; start64 = 1'b0;
        a8 = 8'h5A; b8 = 8'hA5; a64 = 64'h5A5A_5A5A_5A5A_5A5A; b64 = 64'h0;
        lat    = 1;
        busy_1 = w8 ? busy8 : busy64;
        while (!(w8 ? done8 : done64) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (w8) begin q = 64'(q8); r = 64'(r8); z = z8; busy_d = busy8; end
        else    begin q = q64; r = r64; z = z64; busy_d = busy64; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, cyc, first, ndone;
        logic [63:0] q, r;
        logic        z, bd, b1;

        tbl[0]  = '{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10};
        tbl[1]  = '{1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10};
        tbl[2]  = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10};
        tbl[3]  = '{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 10};
        tbl[4]  = '{1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 10};
        tbl[5]  = '{1'b1, 8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, 10};
        tbl[6]  = '{1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 10};
        tbl[7]  = '{1'b1, 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 2};
        tbl[8]  = '{1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 10};
        tbl[9]  = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 10};
        tbl[10] = '{1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 10};
        tbl[11] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 10};

        rst = 1'b1;
        start64 = 1'b0; sm64 = 1'b0; a64 = '0; b64 = '0;
        start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q64", q64, 64'h0);
        check("rst_r64", r64, 64'h0);
        check("rst_flags64", {61'b0, busy64, done64, z64}, 64'h0);
        check("rst_flags8", {61'b0, busy8, done8, z8}, 64'h0);
        rst = 1'b0;

        // 64-bit unsigned 11/3 with exact latency and busy profile
        run_div(1'b0, 1'b0, 64'd11, 64'd3, lat, q, r, z, bd, b1);
        check("u64_11_3_lat", 64'(lat), 64'(div_latency(64)));
        check("u64_11_3_q", q, 64'd3);
        check("u64_11_3_r", r, 64'd2);
        check("u64_11_3_z", 64'(z), 64'd0);
        check("u64_busy_after_accept", 64'(b1), 64'd1);
        check("u64_busy_in_done", 64'(bd), 64'd0);

        // 64-bit divide by zero
        run_div(1'b0, 1'b0, 64'd1234, 64'd0, lat, q, r, z, bd, b1);
        check("dbz64_lat", 64'(lat), 64'd2);
        check("dbz64_q", q, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dbz64_r", r, 64'd1234);
        check("dbz64_z", 64'(z), 64'd1);

        // next valid divide clears the flag
        run_div(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r, z, bd, b1);
        check("u64_100_7_q", q, 64'd14);
        check("u64_100_7_r", r, 64'd2);
        check("u64_clear_z", 64'(z), 64'd0);

        // 64-bit signed overflow and an ordinary signed case
        run_div(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, q, r, z, bd, b1);
        check("s64_ovf_q", q, 64'h8000_0000_0000_0000);
        check("s64_ovf_r", r, 64'h0);
        check("s64_ovf_z", 64'(z), 64'd0);
        run_div(1'b0, 1'b1, -64'sd1000, 64'd7, lat, q, r, z, bd, b1);
        check("s64_m1000_7_q", q, -64'sd142);
        check("s64_m1000_7_r", r, -64'sd6);

        // 8-bit directed table
        for (int i = 0; i < 12; i++) begin
            run_div(1'b1, tbl[i].sm, 64'(tbl[i].a), 64'(tbl[i].b), lat, q, r, z, bd, b1);
            check($sformatf("v%0d_q", i), q, 64'(tbl[i].q));
            check($sformatf("v%0d_r", i), r, 64'(tbl[i].r));
            check($sformatf("v%0d_z", i), 64'(z), 64'(tbl[i].z));
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
        end

        // start held high with changing operands: only acceptance-cycle operands count
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd7;
        cyc = 0; first = 0; ndone = 0;
        while (ndone < 2 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done8) begin
                ndone++;
                if (ndone == 1) begin
                    check("hold_q1", 64'(q8), 64'd14);
                    check("hold_r1", 64'(r8), 64'd2);
                    check("hold_lat1", 64'(cyc), 64'd10);
                    first = cyc;
                    a8 = 8'd50; b8 = 8'd6;
                end else begin
                    check("hold_q2", 64'(q8), 64'd8);
                    check("hold_r2", 64'(r8), 64'd2);
                    check("hold_lat2", 64'(cyc - first), 64'd10);
                    start8 = 1'b0;
                end
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom_range(1, 255));
            end
        end
        check("hold_done_count", 64'(ndone), 64'd2);
        @(posedge clk); #1;
        check("hold_idle_after", 64'(busy8), 64'd0);

        // second start during busy is dropped
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        cyc = 1;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
        @(posedge clk); #1;
        cyc++;
        start8 = 1'b0;
        while (!done8 && cyc < 60) begin @(posedge clk); #1; cyc++; end
        check("drop_lat", 64'(cyc), 64'd10);
        check("drop_q", 64'(q8), 64'd28);
        check("drop_r", 64'(r8), 64'd4);
        ndone = 0;
        repeat (15) begin @(posedge clk); #1; if (done8) ndone++; end
        check("drop_no_extra_done", 64'(ndone), 64'd0);

        // reset during CALC at iteration 20
        start64 = 1'b1; sm64 = 1'b0; a64 = 64'd11; b64 = 64'd3;
        @(posedge clk); #1;
        start64 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy_before_rst", 64'(busy64), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_q", q64, 64'h0);
        check("mid_rst_r", r64, 64'h0);
        check("mid_rst_flags", {61'b0, busy64, done64, z64}, 64'h0);
        ndone = 0;
        repeat (80) begin @(posedge clk); #1; if (done64) ndone++; end
        check("mid_rst_no_done", 64'(ndone), 64'd0);
        run_div(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r, z, bd, b1);
        check("post_rst_q", q, 64'd14);
        check("post_rst_r", r, 64'd2);
        check("post_rst_lat", 64'(lat), 64'd66);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
